// File: rtl/key_sel_debounce_if.sv
// Key conditioning bundle: raw active-low pins in, debounced level, press pulses and mux select out.
interface key_sel_debounce_if;
    logic [1:0] key_raw;
    logic [1:0] key_db;
    logic [1:0] key_press;
    logic [1:0] sel;

    modport master (output key_raw, input key_db, key_press, sel);
    modport slave  (input key_raw, output key_db, key_press, sel);
endinterface

// File: rtl/key_sel_debounce.sv
// Two-key synchroniser/debouncer; each debounced press toggles one mux select bit.
// Latency DEBOUNCE_CNT+2 edges from pin to key_db/key_press/sel; no backpressure, free-running.
module key_sel_debounce #(
    parameter int         DEBOUNCE_CNT = 240000,
    parameter logic [1:0] SEL_INIT     = 2'b00
) (
    input  logic               clk,
    input  logic               rst_n,
    key_sel_debounce_if.slave  kif
);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [1:0]       s1, s2;
    logic [1:0]       key_db_q;
    logic [1:0]       key_press_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1          <= 2'b11;
            s2          <= 2'b11;
            key_db_q    <= 2'b11;
            key_press_q <= 2'b00;
            sel_q       <= SEL_INIT;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1          <= kif.key_raw;
            s2          <= s1;
            key_press_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == key_db_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    key_db_q[i] <= s2[i];
                    cnt[i]      <= '0;
                    // Only the 1->0 (press) transition pulses and walks the mux.
                    if (!s2[i]) begin
                        key_press_q[i] <= 1'b1;
                        sel_q[i]       <= ~sel_q[i];
                    end
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign kif.key_db    = key_db_q;
    assign kif.key_press = key_press_q;
    assign kif.sel       = sel_q;
endmodule

// File: tb/tb_key_sel_debounce.sv
// Directed bench for key_sel_debounce with DEBOUNCE_CNT=4, SEL_INIT=00.
module tb_key_sel_debounce;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   pc0;
    int   pc1;

    key_sel_debounce_if kif ();

    key_sel_debounce #(
        .DEBOUNCE_CNT (4),
        .SEL_INIT     (2'b00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge, sample 1 ns later and tally press pulses.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (kif.key_press[0]) pc0++;
            if (kif.key_press[1]) pc1++;
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; pc0 = 0; pc1 = 0;
        rst_n = 1'b0;
        kif.key_raw = 2'b00;

        // 1: reset with both keys pressed
        for (int k = 0; k < 3; k++) begin
            run(1);
            check("rst_key_db", 32'(kif.key_db), 32'h3);
            check("rst_press", 32'(kif.key_press), 32'h0);
            check("rst_sel", 32'(kif.sel), 32'h0);
        end
        rst_n = 1'b1;
        kif.key_raw = 2'b11;
        run(1);
        check("post_rst_key_db", 32'(kif.key_db), 32'h3);
        check("post_rst_press", 32'(kif.key_press), 32'h0);
        check("post_rst_sel", 32'(kif.sel), 32'h0);
        run(8);

        // 2: 3-cycle glitch is ignored
        kif.key_raw = 2'b10;
        run(3);
        kif.key_raw = 2'b11;
        run(10);
        check("glitch_key_db", 32'(kif.key_db), 32'h3);
        check("glitch_sel", 32'(kif.sel), 32'h0);
        check("glitch_pulses", 32'(pc0 + pc1), 32'h0);

        // 3: press key0, release, press again
        kif.key_raw = 2'b10;
        run(5);
        check("k0_db_before", 32'(kif.key_db), 32'h3);
        check("k0_press_before", 32'(kif.key_press), 32'h0);
        run(1);
        check("k0_db_edge6", 32'(kif.key_db), 32'h2);
        check("k0_press_edge6", 32'(kif.key_press), 32'h1);
        check("k0_sel_edge6", 32'(kif.sel), 32'h1);
        run(1);
        check("k0_press_one_cycle", 32'(kif.key_press), 32'h0);
        run(13);
        check("k0_pc_held", 32'(pc0), 32'h1);
        kif.key_raw = 2'b11;
        run(20);
        check("k0_rel_db", 32'(kif.key_db), 32'h3);
        check("k0_rel_pc", 32'(pc0), 32'h1);
        check("k0_rel_sel", 32'(kif.sel), 32'h1);
        kif.key_raw = 2'b10;
        run(20);
        check("k0_second_sel", 32'(kif.sel), 32'h0);
        check("k0_second_pc", 32'(pc0), 32'h2);
        kif.key_raw = 2'b11;
        run(20);

        // 4: both keys on the same edge
        kif.key_raw = 2'b00;
        run(5);
        check("both_press_before", 32'(kif.key_press), 32'h0);
        check("both_sel_before", 32'(kif.sel), 32'h0);
        run(1);
        check("both_press", 32'(kif.key_press), 32'h3);
        check("both_sel", 32'(kif.sel), 32'h3);
        run(14);
        check("both_pc0", 32'(pc0), 32'h3);
        check("both_pc1", 32'(pc1), 32'h1);
        kif.key_raw = 2'b11;
        run(20);
        check("both_rel_db", 32'(kif.key_db), 32'h3);

        // 5: key1 bounces every 2 cycles, then settles pressed
        for (int s = 0; s < 8; s++) begin
            kif.key_raw = (s % 2 == 0) ? 2'b01 : 2'b11;
            run(2);
        end
        check("bounce_pc1", 32'(pc1), 32'h1);
        check("bounce_db", 32'(kif.key_db), 32'h3);
        kif.key_raw = 2'b01;
        run(20);
        check("bounce_hold_pc1", 32'(pc1), 32'h2);
        check("bounce_hold_sel", 32'(kif.sel), 32'h1);
        check("bounce_hold_db", 32'(kif.key_db), 32'h1);
        kif.key_raw = 2'b11;
        run(20);
        check("bounce_rel_db", 32'(kif.key_db), 32'h3);

        // 6: reset mid-count discards progress
        kif.key_raw = 2'b10;
        run(4);
        rst_n = 1'b0;
        run(1);
        check("midrst_db", 32'(kif.key_db), 32'h3);
        check("midrst_press", 32'(kif.key_press), 32'h0);
        check("midrst_sel", 32'(kif.sel), 32'h0);
        rst_n = 1'b1;
        run(5);
        check("midrst_press_early", 32'(kif.key_press), 32'h0);
        check("midrst_db_early", 32'(kif.key_db), 32'h3);
        run(1);
        check("midrst_press", 32'(kif.key_press), 32'h1);
        check("midrst_sel_after", 32'(kif.sel), 32'h1);
        check("midrst_db_after", 32'(kif.key_db), 32'h2);
        run(10);
        check("midrst_pc0", 32'(pc0), 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
